lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit controller in front of a word-wide data memory.
// Accepts one access at a time, checks it, performs load extraction or a
// read-modify-write for sub-word stores, and returns a one-cycle response.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we, req_funct3  store flag and RV32I width/sign code
//   req_addr, req_wdata byte address and right-aligned store data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata, rsp_err  registered load result / rejection flag
//   mem_addr            byte address to the word memory (low 2 bits ignored)
//   mem_wdata, mem_wren full word to write and its write strobe
//   mem_rdata           combinational read of the word at mem_addr
module lsu_ctrl #(
  parameter int unsigned DEPTH = 2048
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [2:0]                 req_funct3,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       rsp_valid,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH)-1:0]   mem_addr,
  output logic [31:0]                mem_wdata,
  output logic                       mem_wren,
  input  logic [31:0]                mem_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic          acc_err_c;
  logic [31:0]   load_c;
  logic [31:0]   merge_c;

  // Reject illegal width codes, misaligned halfword/word accesses and
  // addresses beyond the memory.
  always_comb begin
    logic f3_bad;
    logic misaligned;
    logic out_of_range;
    f3_bad       = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    if (req_we) f3_bad = !(req_funct3 inside {F_B, F_H, F_W});
    else        f3_bad = !(req_funct3 inside {F_B, F_H, F_W, F_BU, F_HU});
    misaligned   = ((req_funct3 == F_H || req_funct3 == F_HU) && req_addr[0]) ||
                   (req_funct3 == F_W && req_addr[1:0] != 2'b00);
    out_of_range = |req_addr[31:AW];
    acc_err_c    = f3_bad || misaligned || out_of_range;
  end

  // Load lane extraction with sign/zero extension.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = 8'h00;
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (addr_q[1:0])
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    case (f3_q)
      F_B:     load_c = {{24{lane_b[7]}}, lane_b};
      F_BU:    load_c = {24'h000000, lane_b};
      F_H:     load_c = {{16{lane_h[15]}}, lane_h};
      F_HU:    load_c = {16'h0000, lane_h};
      default: load_c = mem_rdata;
    endcase
  end

  // Sub-word store merge: replace the addressed lane(s) of the current word.
  always_comb begin
    merge_c = mem_rdata;
    if (f3_q == F_H) begin
      if (addr_q[1]) merge_c[31:16] = data_q[15:0];
      else           merge_c[15:0]  = data_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merge_c[7:0]   = data_q[7:0];
        2'd1:    merge_c[15:8]  = data_q[7:0];
        2'd2:    merge_c[23:16] = data_q[7:0];
        default: merge_c[31:24] = data_q[7:0];
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (acc_err_c)               state_d = S_RESP;
          else if (!req_we)            state_d = S_LOAD;
          else if (req_funct3 == F_W)  state_d = S_WRITE;
          else                         state_d = S_READ;
        end
      end
      S_LOAD:  state_d = S_RESP;
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, store-data/merge register and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= '0;
      data_q    <= 32'h0;
    end else begin
      req_ready <= (state_d == S_IDLE);
      rsp_valid <= (state_d == S_RESP);
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            f3_q   <= req_funct3;
            addr_q <= req_addr[AW-1:0];
            data_q <= req_wdata;
            if (acc_err_c) begin
              rsp_rdata <= 32'h0;
              rsp_err   <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          rsp_rdata <= load_c;
          rsp_err   <= 1'b0;
        end
        // data_q becomes the full word written back in WRITE.
        S_READ: data_q <= merge_c;
        S_WRITE: begin
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  // Gated by rst so a store interrupted in WRITE never commits.
  assign mem_wren  = (state_q == S_WRITE) && !rst;

endmodule
